// File: rtl/adder_pkg.sv
// Shared state encoding and default geometry for the word-serial adder sequencer.
package adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int N_DEF = 5;
    localparam int K_DEF = 4;
endpackage

// File: rtl/adder_str.sv
// N-bit structural adder slice shared across words by the sequencer.
module adder_str #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/adder_seq_ctrl.sv
// Word-serial wide adder: one N-bit word per clock through a single shared
// adder_str, carry registered between words, valid/ready on both sides.
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter  int N = N_DEF,
    parameter  int K = K_DEF,
    localparam int W = N * K
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    w_acc_next;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    w_s;
    logic            w_cout;
    logic            w_last;

    adder_str #(.N(N)) u_add (
        .a   (r_a[r_idx*N +: N]),
        .b   (r_b[r_idx*N +: N]),
        .cin (r_carry),
        .s   (w_s),
        .cout(w_cout)
    );

    assign w_last = (r_idx == IW'(K - 1));

    always_comb begin
        w_acc_next               = r_acc;
        w_acc_next[r_idx*N +: N] = w_s;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Working accumulator is cleared on accept; the visible sum/cout only
    // update when a result completes, so they stay put across transfers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_sum  <= w_acc_next;
                        r_cout <= w_cout;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed + random bench for adder_seq_ctrl with a transaction-level model,
// plus a second small instance swept exhaustively.
module tb_adder_seq_ctrl;
    localparam int N  = 5;
    localparam int K  = 4;
    localparam int W  = N * K;
    localparam int N2 = 3;
    localparam int K2 = 2;
    localparam int W2 = N2 * K2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          in_ready, out_valid, cout, busy;
    logic [W-1:0]  sum;

    logic          in_valid2 = 1'b0, cin2 = 1'b0;
    logic          out_ready2 = 1'b1;
    logic [W2-1:0] a2 = '0, b2 = '0;
    logic          in_ready2, out_valid2, cout2, busy2;
    logic [W2-1:0] sum2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.N(N), .K(K)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    adder_seq_ctrl #(.N(N2), .K(K2)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: 0 = waiting for operands, 1 = computing, 2 = holding a result.
    int           m_mode = 0;
    int           m_cnt = 0;
    logic [W:0]   m_exp = '0;
    logic [W:0]   m_last = '0;
    bit           m_seen_rst = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_mode     <= 0;
            m_cnt      <= 0;
            m_last     <= '0;
            m_seen_rst <= 1'b1;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_exp  <= {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                    m_cnt  <= 1;
                    m_mode <= 1;
                end
                1: if (m_cnt == K) begin
                    m_mode <= 2;
                    m_last <= m_exp;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (out_ready) m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_seen_rst) begin
            check("in_ready", 64'(in_ready), 64'(m_mode == 0));
            check("out_valid", 64'(out_valid), 64'(m_mode == 2));
            check("busy", 64'(busy), 64'(m_mode != 0));
            check("cout_sum", 64'({cout, sum}), 64'(m_last));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input int stall, output logic [W:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
        res = {cout, sum};
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [W:0] res;
    int         lat;

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);

        do_op(20'h00001, 20'h0001F, 1'b0, 0, res, lat);
        check("small_latency", 64'(lat), 64'd4);
        check("small_result", 64'(res), 64'h000020);

        do_op(20'hFFFFF, 20'h00000, 1'b1, 1, res, lat);
        check("ripple_result", 64'(res), 64'h100000);
        check("held_after_xfer", 64'({cout, sum}), 64'h100000);

        // Back-pressure with a competing request that must wait for the transfer.
        a = 20'hFFFFF; b = 20'hFFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        a = 20'h00001; b = 20'h00002; cin = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 6; i++) begin
            check("bp_sum", 64'({cout, sum}), 64'h1FFFFF);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_after_xfer", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_taken", 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("bp_second_result", 64'({cout, sum}), 64'h000003);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a computation.
        a = 20'h12345; b = 20'h0ABCD; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sum", 64'({cout, sum}), 64'd0);
        do_op(20'h00003, 20'h00004, 1'b0, 0, res, lat);
        check("post_rst_result", 64'(res), 64'h000007);

        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            do_op(ra, rb, rc, int'($urandom_range(0, 3)), res, lat);
            check("rand_result", 64'(res), 64'({1'b0, ra} + {1'b0, rb} + (W+1)'(rc)));
            check("rand_latency", 64'(lat), 64'(K));
        end

        for (int ia = 0; ia < (1 << W2); ia++) begin
            for (int ib = 0; ib < (1 << W2); ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int n;
                    a2 = W2'(ia); b2 = W2'(ib); cin2 = 1'(ic); in_valid2 = 1'b1;
                    tick();
                    in_valid2 = 1'b0;
                    n = 0;
                    while (!out_valid2 && n < 10) begin tick(); n++; end
                    check("sweep_result", 64'({cout2, sum2}), 64'(ia + ib + ic));
                    tick();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
